// File: rtl/mem_controller_if.sv
// Request/response bus between the consumers (LSUs or fetchers), the memory
// controller and the external memory channels. All multi-lane signals are
// flat packed vectors, lane k occupying bits [k*W +: W].
interface mem_controller_if #(
    parameter int ADDR_BITS     = 32,
    parameter int DATA_BITS     = 32,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]            mem_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]            mem_write_ready;

    // Controller view: serves consumers, drives memory channels.
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    // Environment view: consumers and memory together.
    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_controller.sv
// Memory controller: arbitrates NUM_CONSUMERS requesters onto NUM_CHANNELS
// memory channels, lowest consumer index and lowest channel index first.
// Each channel runs IDLE -> READ/WRITE_WAITING -> RELAYING -> IDLE. All
// outputs come straight from registers.
module mem_controller #(
    parameter int ADDR_BITS     = 32,
    parameter int DATA_BITS     = 32,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_controller_if.slave bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } chan_state_t;

    chan_state_t                        state_q [NUM_CHANNELS];
    chan_state_t                        state_d [NUM_CHANNELS];
    logic [CW-1:0]                      cur_q   [NUM_CHANNELS];
    logic [CW-1:0]                      cur_d   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]           serving_q, serving_d;
    logic [NUM_CONSUMERS-1:0]           claimed, released;

    logic [NUM_CHANNELS-1:0]            mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]           crr_q, crr_d, cwr_q, cwr_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

    // Next-state and next-output logic for every channel. Channels are walked
    // in index order so a claim by a lower channel is visible to higher ones;
    // releases are collected separately and only take effect next cycle.
    always_comb begin
        logic found;
        state_d  = state_q;
        cur_d    = cur_q;
        mrv_d    = mrv_q;
        mra_d    = mra_q;
        mwv_d    = mwv_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        crr_d    = crr_q;
        cwr_d    = cwr_q;
        crd_d    = crd_q;
        claimed  = serving_q;
        released = '0;
        found    = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            case (state_q[ch])
                IDLE: begin
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (!found && !claimed[i]) begin
                            if (bus.consumer_read_valid[i]) begin
                                found      = 1'b1;
                                claimed[i] = 1'b1;
                                cur_d[ch]  = CW'(i);
                                mrv_d[ch]  = 1'b1;
                                mra_d[ch*ADDR_BITS +: ADDR_BITS] =
                                    bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                                state_d[ch] = READ_WAITING;
                            end else if ((WRITE_ENABLE != 0) && bus.consumer_write_valid[i]) begin
                                found      = 1'b1;
                                claimed[i] = 1'b1;
                                cur_d[ch]  = CW'(i);
                                mwv_d[ch]  = 1'b1;
                                mwa_d[ch*ADDR_BITS +: ADDR_BITS] =
                                    bus.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                                mwd_d[ch*DATA_BITS +: DATA_BITS] =
                                    bus.consumer_write_data[i*DATA_BITS +: DATA_BITS];
                                state_d[ch] = WRITE_WAITING;
                            end
                        end
                    end
                end
                READ_WAITING: begin
                    if (bus.mem_read_ready[ch]) begin
                        mrv_d[ch]          = 1'b0;
                        crr_d[cur_q[ch]]   = 1'b1;
                        crd_d[cur_q[ch]*DATA_BITS +: DATA_BITS] =
                            bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
                        state_d[ch]        = RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (bus.mem_write_ready[ch]) begin
                        mwv_d[ch]        = 1'b0;
                        cwr_d[cur_q[ch]] = 1'b1;
                        state_d[ch]      = RELAYING;
                    end
                end
                RELAYING: begin
                    if (!bus.consumer_read_valid[cur_q[ch]] &&
                        !bus.consumer_write_valid[cur_q[ch]]) begin
                        crr_d[cur_q[ch]]    = 1'b0;
                        cwr_d[cur_q[ch]]    = 1'b0;
                        released[cur_q[ch]] = 1'b1;
                        state_d[ch]         = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
        serving_d = claimed & ~released;
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cur_q[ch]   <= '0;
            end
            serving_q <= '0;
            mrv_q     <= '0;
            mra_q     <= '0;
            mwv_q     <= '0;
            mwa_q     <= '0;
            mwd_q     <= '0;
            crr_q     <= '0;
            cwr_q     <= '0;
            crd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            serving_q <= serving_d;
            mrv_q     <= mrv_d;
            mra_q     <= mra_d;
            mwv_q     <= mwv_d;
            mwa_q     <= mwa_d;
            mwd_q     <= mwd_d;
            crr_q     <= crr_d;
            cwr_q     <= cwr_d;
            crd_q     <= crd_d;
        end
    end

    assign bus.mem_read_valid       = mrv_q;
    assign bus.mem_read_address     = mra_q;
    assign bus.consumer_read_ready  = crr_q;
    assign bus.consumer_read_data   = crd_q;
    // A read-only instance keeps the whole write path at constant zero.
    assign bus.mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
    assign bus.mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
    assign bus.mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;
    assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ? cwr_q : '0;
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: a behavioural memory with programmable latency
// answers each channel, a scoreboard of expected consumer responses is filled
// as requests are issued and drained as consumer ready bits rise.
module tb_mem_controller;
    localparam int AB  = 32;
    localparam int DB  = 32;
    localparam int NC  = 8;
    localparam int NCH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_controller_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) bus ();
    mem_controller_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) ro_bus ();

    mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                     .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                     .NUM_CHANNELS(NCH), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset), .bus(ro_bus));

    // The read-only build sees the same write requests and a silent memory.
    assign ro_bus.consumer_read_valid    = '0;
    assign ro_bus.consumer_read_address  = '0;
    assign ro_bus.consumer_write_valid   = bus.consumer_write_valid;
    assign ro_bus.consumer_write_address = bus.consumer_write_address;
    assign ro_bus.consumer_write_data    = bus.consumer_write_data;
    assign ro_bus.mem_read_ready         = '0;
    assign ro_bus.mem_read_data          = '0;
    assign ro_bus.mem_write_ready        = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          wr;
        int          cons;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem_store [logic [31:0]];
    int          lat = 0;
    int          cnt [NCH];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each channel after `lat` waiting cycles.
    initial begin
        bus.mem_read_ready  = '0;
        bus.mem_write_ready = '0;
        bus.mem_read_data   = {NCH{32'h5555_5555}};
        for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
        forever begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                logic [31:0] a;
                if (!bus.mem_read_valid[ch] && !bus.mem_write_valid[ch]) begin
                    bus.mem_read_ready[ch]  = 1'b0;
                    bus.mem_write_ready[ch] = 1'b0;
                    bus.mem_read_data[ch*DB +: DB] = 32'h5555_5555;
                    cnt[ch] = 0;
                end else if (bus.mem_read_ready[ch] || bus.mem_write_ready[ch]) begin
                    bus.mem_read_ready[ch]  = 1'b0;
                    bus.mem_write_ready[ch] = 1'b0;
                    bus.mem_read_data[ch*DB +: DB] = 32'h5555_5555;
                    cnt[ch] = 0;
                end else if (cnt[ch] >= lat) begin
                    cnt[ch] = 0;
                    if (bus.mem_read_valid[ch]) begin
                        a = bus.mem_read_address[ch*AB +: AB];
                        bus.mem_read_data[ch*DB +: DB] = mem_store.exists(a) ? mem_store[a] : (32'hBAD0_0000 ^ a);
                        bus.mem_read_ready[ch] = 1'b1;
                    end else begin
                        a = bus.mem_write_address[ch*AB +: AB];
                        mem_store[a] = bus.mem_write_data[ch*DB +: DB];
                        bus.mem_write_ready[ch] = 1'b1;
                    end
                end else begin
                    cnt[ch]++;
                end
            end
        end
    end

    // Scoreboard drain: every rising consumer ready must match a pending entry.
    initial begin
        logic [NC-1:0] prev_rr;
        logic [NC-1:0] prev_wr;
        prev_rr = '0;
        prev_wr = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (bus.consumer_read_ready[c] && !prev_rr[c]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && !sb[k].wr && sb[k].cons == c) idx = k;
                    if (idx < 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_ready_unexpected c%0d: got ready 1, want 0", c);
                    end else begin
                        check($sformatf("rd_data_c%0d", c), bus.consumer_read_data[c*DB +: DB], sb[idx].data);
                        sb.delete(idx);
                    end
                end
                if (bus.consumer_write_ready[c] && !prev_wr[c]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].wr && sb[k].cons == c) idx = k;
                    if (idx < 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL wr_ready_unexpected c%0d: got ready 1, want 0", c);
                    end else begin
                        check($sformatf("wr_mem_c%0d", c),
                              mem_store.exists(sb[idx].addr) ? mem_store[sb[idx].addr] : 32'hXXXX_XXXX,
                              sb[idx].data);
                        sb.delete(idx);
                    end
                end
            end
            prev_rr = bus.consumer_read_ready;
            prev_wr = bus.consumer_write_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // One isolated transaction on an idle controller (served by channel 0).
    task automatic do_txn(input bit wr, input int c, input logic [31:0] addr,
                          input logic [31:0] data, input int latency);
        int cyc;
        bit got;
        logic rdy;
        lat = latency;
        sb.push_back('{wr, c, addr, data});
        if (wr) begin
            bus.consumer_write_address[c*AB +: AB] = addr;
            bus.consumer_write_data[c*DB +: DB]    = data;
            bus.consumer_write_valid[c]            = 1'b1;
        end else begin
            bus.consumer_read_address[c*AB +: AB] = addr;
            bus.consumer_read_valid[c]            = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (cyc < latency + 10 && !got) begin
            tick();
            cyc++;
            rdy = wr ? bus.consumer_write_ready[c] : bus.consumer_read_ready[c];
            if (rdy) begin
                got = 1'b1;
            end else if (wr) begin
                check("mem_write_valid", bus.mem_write_valid, 2'b01);
                check("mem_write_address", bus.mem_write_address[AB-1:0], addr);
                check("mem_write_data", bus.mem_write_data[DB-1:0], data);
                check("ro_mem_write_valid", ro_bus.mem_write_valid, 0);
            end else begin
                check("mem_read_valid", bus.mem_read_valid, 2'b01);
                check("mem_read_address", bus.mem_read_address[AB-1:0], addr);
            end
        end
        check($sformatf("latency_c%0d", c), cyc, latency + 2);
        tick();
        rdy = wr ? bus.consumer_write_ready[c] : bus.consumer_read_ready[c];
        check("ready_held", rdy, 1);
        if (wr) bus.consumer_write_valid[c] = 1'b0;
        else    bus.consumer_read_valid[c]  = 1'b0;
        tick();
        rdy = wr ? bus.consumer_write_ready[c] : bus.consumer_read_ready[c];
        check("ready_cleared", rdy, 0);
        if (wr) check("ro_consumer_write_ready", ro_bus.consumer_write_ready, 0);
    endtask

    typedef struct {
        bit          wr;
        int          cons;
        logic [31:0] addr;
        logic [31:0] data;
        int          latency;
        bit          preload;
    } vec_t;

    initial begin
        vec_t vecs [7];
        bit   got;
        vecs[0] = '{1'b0, 3, 32'h0000_0040, 32'hDEAD_BEEF, 1,  1'b1};
        vecs[1] = '{1'b1, 2, 32'h0000_0010, 32'h0000_1234, 0,  1'b0};
        vecs[2] = '{1'b0, 2, 32'h0000_0010, 32'h0000_1234, 0,  1'b0};
        vecs[3] = '{1'b0, 7, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 2,  1'b1};
        vecs[4] = '{1'b1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 3,  1'b0};
        vecs[5] = '{1'b0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0,  1'b0};
        vecs[6] = '{1'b0, 1, 32'h0000_0200, 32'h0BAD_CAFE, 20, 1'b1};

        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;

        reset = 1'b1;
        tick(); tick(); tick();
        check("rst_mem_read_valid", bus.mem_read_valid, 0);
        check("rst_mem_write_valid", bus.mem_write_valid, 0);
        check("rst_consumer_read_ready", bus.consumer_read_ready, 0);
        check("rst_consumer_write_ready", bus.consumer_write_ready, 0);
        check("rst_consumer_read_data", bus.consumer_read_data, 0);
        check("rst_mem_read_address", bus.mem_read_address, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].preload) mem_store[vecs[v].addr] = vecs[v].data;
            do_txn(vecs[v].wr, vecs[v].cons, vecs[v].addr, vecs[v].data, vecs[v].latency);
        end

        // Three readers, two channels.
        mem_store[32'h100] = 32'h1000_0000;
        mem_store[32'h104] = 32'h1040_0001;
        mem_store[32'h114] = 32'h1140_0005;
        sb.push_back('{1'b0, 0, 32'h100, 32'h1000_0000});
        sb.push_back('{1'b0, 1, 32'h104, 32'h1040_0001});
        sb.push_back('{1'b0, 5, 32'h114, 32'h1140_0005});
        lat = 3;
        bus.consumer_read_address[0*AB +: AB] = 32'h100;
        bus.consumer_read_address[1*AB +: AB] = 32'h104;
        bus.consumer_read_address[5*AB +: AB] = 32'h114;
        bus.consumer_read_valid = 8'b0010_0011;
        tick();
        check("cont_c1_valid", bus.mem_read_valid, 2'b11);
        check("cont_c1_addr0", bus.mem_read_address[0*AB +: AB], 32'h100);
        check("cont_c1_addr1", bus.mem_read_address[1*AB +: AB], 32'h104);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("cont_wait_ready", bus.consumer_read_ready, 0);
        end
        tick();
        check("cont_c5_ready", bus.consumer_read_ready, 8'b0000_0011);
        bus.consumer_read_valid[0] = 1'b0;
        tick();
        check("cont_c6_valid", bus.mem_read_valid, 2'b00);
        check("cont_c6_ready", bus.consumer_read_ready, 8'b0000_0010);
        tick();
        check("cont_c7_valid", bus.mem_read_valid, 2'b01);
        check("cont_c7_addr0", bus.mem_read_address[0*AB +: AB], 32'h114);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus.consumer_read_ready[5]) got = 1'b1;
        end
        check("cont_c5_served", got, 1);
        bus.consumer_read_valid = '0;
        tick();
        check("cont_all_cleared", bus.consumer_read_ready, 0);
        tick();

        // Read and write on the same consumer: read first.
        mem_store[32'h44] = 32'h4444_0001;
        sb.push_back('{1'b0, 4, 32'h44, 32'h4444_0001});
        lat = 0;
        bus.consumer_read_address[4*AB +: AB]  = 32'h44;
        bus.consumer_write_address[4*AB +: AB] = 32'h48;
        bus.consumer_write_data[4*DB +: DB]    = 32'h0000_4848;
        bus.consumer_read_valid[4]  = 1'b1;
        bus.consumer_write_valid[4] = 1'b1;
        tick();
        check("rw_c1_read_valid", bus.mem_read_valid, 2'b01);
        check("rw_c1_write_valid", bus.mem_write_valid, 2'b00);
        tick();
        check("rw_c2_read_ready", bus.consumer_read_ready[4], 1);
        check("rw_c2_write_ready", bus.consumer_write_ready[4], 0);
        tick();
        check("rw_c3_write_valid", bus.mem_write_valid, 2'b00);
        bus.consumer_read_valid[4]  = 1'b0;
        bus.consumer_write_valid[4] = 1'b0;
        tick();
        check("rw_c4_read_ready", bus.consumer_read_ready[4], 0);
        do_txn(1'b1, 4, 32'h48, 32'h0000_4848, 0);

        // Reset while both channels are waiting on memory.
        lat = 50;
        bus.consumer_read_address[0*AB +: AB] = 32'h300;
        bus.consumer_read_address[6*AB +: AB] = 32'h600;
        bus.consumer_read_valid = 8'b0100_0001;
        tick();
        check("rst_mid_valid", bus.mem_read_valid, 2'b11);
        check("rst_mid_addr1", bus.mem_read_address[1*AB +: AB], 32'h600);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_mem_read_valid", bus.mem_read_valid, 0);
        check("rst_mid_mem_read_address", bus.mem_read_address, 0);
        check("rst_mid_consumer_ready", bus.consumer_read_ready, 0);
        check("rst_mid_serving", dut.serving_q, 0);
        reset = 1'b0;
        bus.consumer_read_valid = '0;
        tick();
        mem_store[32'h600] = 32'h6666_0006;
        do_txn(1'b0, 6, 32'h600, 32'h6666_0006, 0);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
